// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full/almost-empty thresholds
// and sticky overflow/underflow error bits for the downstream flow-control FSM.
module fifo_umbral #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  error_full,
  output logic                  error_empty
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;
  assign full         = count == (ADDR_WIDTH + 1)'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= umbral_alto;
  assign almost_empty = count <= umbral_bajo;
  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      error_full  <= 1'b0;
      error_empty <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (rd_acc) data_out <= mem[rd_ptr];
      valid_out <= rd_acc;
      if (wr_acc && !rd_acc) count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if (wr_en && !wr_acc) error_full <= 1'b1;
      if (rd_en && !rd_acc) error_empty <= 1'b1;
    end
endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed self-checking bench for fifo_umbral.
module tb_fifo_umbral;
  logic       clk, reset, wr_en, rd_en;
  logic [7:0] data_in, data_out;
  logic [3:0] umbral_alto, umbral_bajo, count;
  logic       valid_out, full, almost_full, empty, almost_empty, error_full, error_empty;
  int total = 0, bad = 0;
  logic [7:0] drain_exp [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};

  fifo_umbral dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo), .data_out(data_out),
    .valid_out(valid_out), .count(count), .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty), .error_full(error_full),
    .error_empty(error_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_errf", error_full, 0);
    chk("rst_erre", error_empty, 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 0; rd_en = 0; data_in = 0;
    umbral_bajo = 4'd2; umbral_alto = 4'd6;
    #2 reset = 1'b0;
    #10 chk_reset_state();
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1; data_in = 8'(i);
      step();
      chk("fill_count", count, i);
      chk("fill_aempty", almost_empty, i <= 2);
      chk("fill_afull", almost_full, i >= 6);
      chk("fill_full", full, i == 8);
    end
    data_in = 8'h55;
    step();
    chk("ovf_count", count, 8);
    chk("ovf_errf", error_full, 1);
    chk("ovf_valid", valid_out, 0);
    wr_en = 0;
    step();
    chk("ovf_sticky", error_full, 1);
    wr_en = 1; rd_en = 1; data_in = 8'hAA;
    step();
    chk("fullrw_dout", data_out, 8'h01);
    chk("fullrw_valid", valid_out, 1);
    chk("fullrw_count", count, 8);
    chk("fullrw_full", full, 1);
    wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_dout", data_out, drain_exp[i]);
      chk("drain_valid", valid_out, 1);
      chk("drain_count", count, 7 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_erre", error_empty, 0);
    step();
    chk("udf_valid", valid_out, 0);
    chk("udf_erre", error_empty, 1);
    chk("udf_count", count, 0);
    chk("udf_dout_hold", data_out, 8'hAA);
    rd_en = 0;
    umbral_bajo = 4'd0; umbral_alto = 4'd0;
    #1;
    chk("thr0_aempty", almost_empty, 1);
    chk("thr0_afull", almost_full, 1);
    umbral_bajo = 4'd2; umbral_alto = 4'd6;
    #1;
    chk("thr_back_afull", almost_full, 0);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; data_in = 8'(8'h10 + i);
      step();
    end
    wr_en = 0;
    chk("pre_rst_count", count, 5);
    reset = 1'b0;
    #2 chk_reset_state();
    step();
    reset = 1'b1;
    wr_en = 1; rd_en = 1; data_in = 8'h33;
    step();
    chk("emptyrw_count", count, 1);
    chk("emptyrw_valid", valid_out, 0);
    chk("emptyrw_erre", error_empty, 1);
    wr_en = 0;
    step();
    chk("post_rst_dout", data_out, 8'h33);
    chk("post_rst_valid", valid_out, 1);
    chk("post_rst_count", count, 0);
    rd_en = 0;
    step();
    chk("final_valid", valid_out, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
